cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the Tomasulo core. It shares the single result bus between the four reservation-station/functional-unit pairs (ADD1, ADD2, LOAD1, LOAD2) that complete results. It picks one requester per cycle, round-robin or fixed priority, and broadcasts the winner's tag and data to the register status table and the waiting stations. The one-cycle grant pulse tells the winner to free itself.

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_if.sv | 25 ++
 rtl/cdb_arbiter_rr_priority_picker.sv | 30 +++
 rtl/cdb_arbiter.sv | 75 +++++++
 tb/tb_cdb_arbiter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo dispatch constants: station tags, the no-value bus pattern,
// and the conversions between requester index and station tag.
package cdb_arbiter_pkg;

   localparam int N_STATIONS = 4;
   localparam int RESULT_W   = 16;

   typedef enum logic [2:0] {
      FREE_REGISTER     = 3'd0,
      RES_STATION_ADD1  = 3'd1,
      RES_STATION_ADD2  = 3'd2,
      RES_STATION_LOAD1 = 3'd3,
      RES_STATION_LOAD2 = 3'd4
   } rs_tag_e;

   localparam logic [15:0] NO_VALUE = 16'hFFF0;

   function automatic rs_tag_e req_idx_to_tag(input logic [1:0] idx);
      logic [2:0] t;
      t = {1'b0, idx} + 3'd1;
      return rs_tag_e'(t);
   endfunction

   function automatic logic [1:0] tag_to_req_idx(input rs_tag_e tag);
      logic [2:0] t;
      t = 3'(tag) - 3'd1;
      return t[1:0];
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Station-side request bus and common-data-bus broadcast of the arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_STATIONS,
   parameter int DATA_W = RESULT_W
);
   logic [N_REQ-1:0]             Req;
   logic [N_REQ-1:0][DATA_W-1:0] Req_data;
   logic [N_REQ-1:0]             Grant;
   logic                         CDB_valid;
   logic [2:0]                   CDB_tag;
   logic [DATA_W-1:0]            CDB_data;
   logic [15:0]                  Grant_count;

   modport master (
      output Req, Req_data,
      input  Grant, CDB_valid, CDB_tag, CDB_data, Grant_count
   );

   modport slave (
      input  Req, Req_data,
      output Grant, CDB_valid, CDB_tag, CDB_data, Grant_count
   );
endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Combinational circular priority search: first eligible index at or above
// start_ptr, wrapping to index 0.
module rr_priority_picker
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = N_STATIONS,
   localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] eligible,
   input  logic [IW-1:0]    start_ptr,
   output logic             valid,
   output logic [IW-1:0]    win_idx
);
   int   idx_s;
   logic hit_s;

   // Scan from the farthest candidate back to start_ptr so the nearest hit is written last.
   always_comb begin
      valid   = 1'b0;
      win_idx = '0;
      idx_s   = 0;
      hit_s   = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx_s   = (int'(start_ptr) + k) % N_REQ;
         hit_s   = eligible[IW'(idx_s)];
         valid   = valid | hit_s;
         win_idx = hit_s ? IW'(idx_s) : win_idx;
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one completing station per cycle wins the result
// bus, chosen round-robin or by fixed priority, with a one-cycle grant pulse.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ     = N_STATIONS,
   parameter int DATA_W    = RESULT_W,
   parameter bit RR_ENABLE = 1'b1
)(
   input logic          Clock,
   input logic          Reset,
   cdb_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  grant_r;
   logic              valid_r;
   rs_tag_e           tag_r;
   logic [DATA_W-1:0] data_r;
   logic [15:0]       count_r;
   logic [IW-1:0]     ptr_r;

   logic [N_REQ-1:0]  eligible_s;
   logic [N_REQ-1:0]  grant_next_s;
   logic [IW-1:0]     start_s;
   logic [IW-1:0]     win_idx_s;
   logic [IW-1:0]     ptr_next_s;
   logic              win_valid_s;

   // Last cycle's grant doubles as the mask, keeping a station that is still
   // dropping Req from winning twice in a row.
   assign eligible_s   = bus.Req & ~grant_r;
   assign start_s      = RR_ENABLE ? ptr_r : '0;
   assign grant_next_s = N_REQ'(1) << win_idx_s;
   assign ptr_next_s   = (win_idx_s == IW'(N_REQ - 1)) ? '0 : win_idx_s + IW'(1);

   rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
      .eligible  (eligible_s),
      .start_ptr (start_s),
      .valid     (win_valid_s),
      .win_idx   (win_idx_s)
   );

   // Broadcast registers, round-robin pointer and saturating result counter.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         grant_r <= '0;
         valid_r <= 1'b0;
         tag_r   <= FREE_REGISTER;
         data_r  <= DATA_W'(NO_VALUE);
         count_r <= 16'd0;
         ptr_r   <= '0;
      end else if (win_valid_s) begin
         grant_r <= grant_next_s;
         valid_r <= 1'b1;
         tag_r   <= req_idx_to_tag(2'(win_idx_s));
         data_r  <= bus.Req_data[win_idx_s];
         count_r <= (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
         ptr_r   <= ptr_next_s;
      end else begin
         grant_r <= '0;
         valid_r <= 1'b0;
         tag_r   <= FREE_REGISTER;
         data_r  <= DATA_W'(NO_VALUE);
         count_r <= count_r;
         ptr_r   <= ptr_r;
      end
   end

   assign bus.Grant       = grant_r;
   assign bus.CDB_valid   = valid_r;
   assign bus.CDB_tag     = 3'(tag_r);
   assign bus.CDB_data    = data_r;
   assign bus.Grant_count = count_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one round-robin and one fixed-priority
// instance share clock and reset; expectations are hand-computed.
module tb_cdb_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cdb_arbiter_if #(.N_REQ(4), .DATA_W(16)) if_rr ();
   cdb_arbiter_if #(.N_REQ(4), .DATA_W(16)) if_fx ();

   cdb_arbiter #(.N_REQ(4), .DATA_W(16), .RR_ENABLE(1'b1)) u_rr (
      .Clock (clk),
      .Reset (rst),
      .bus   (if_rr.slave)
   );

   cdb_arbiter #(.N_REQ(4), .DATA_W(16), .RR_ENABLE(1'b0)) u_fx (
      .Clock (clk),
      .Reset (rst),
      .bus   (if_fx.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-priority table: Req before each edge and the expected winner.
   logic [3:0] fx_req [7] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1001};
   int         fx_win [7] = '{0, 3, 0, 3, 0, 1, 0};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rr(input string tag, input logic [3:0] g, input logic v,
                           input logic [2:0] t, input logic [15:0] d, input logic [15:0] c);
      check_eq({tag, ".grant"}, 32'(if_rr.Grant), 32'(g));
      check_eq({tag, ".valid"}, 32'(if_rr.CDB_valid), 32'(v));
      check_eq({tag, ".tag"},   32'(if_rr.CDB_tag), 32'(t));
      check_eq({tag, ".data"},  32'(if_rr.CDB_data), 32'(d));
      check_eq({tag, ".count"}, 32'(if_rr.Grant_count), 32'(c));
   endtask

   task automatic check_fx(input string tag, input logic [3:0] g, input logic v,
                           input logic [2:0] t, input logic [15:0] d, input logic [15:0] c);
      check_eq({tag, ".grant"}, 32'(if_fx.Grant), 32'(g));
      check_eq({tag, ".valid"}, 32'(if_fx.CDB_valid), 32'(v));
      check_eq({tag, ".tag"},   32'(if_fx.CDB_tag), 32'(t));
      check_eq({tag, ".data"},  32'(if_fx.CDB_data), 32'(d));
      check_eq({tag, ".count"}, 32'(if_fx.Grant_count), 32'(c));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      if_rr.Req = 4'b1111;
      if_fx.Req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         if_rr.Req_data[i] = 16'hA000 + 16'(i);
         if_fx.Req_data[i] = 16'hB000 + 16'(i);
      end

      // Reset held for two edges with every station requesting.
      tick();
      tick();
      check_rr("rst_rr", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd0);
      check_fx("rst_fx", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd0);

      // Full contention, round robin: 0,1,2,3,0.
      rst = 1'b1;
      if_fx.Req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_rr($sformatf("rr%0d", i), 4'b0001 << (i % 4), 1'b1,
                  3'((i % 4) + 1), 16'hA000 + 16'(i % 4), 16'(i + 1));
      end
      if_rr.Req = 4'b0000;
      tick();
      check_rr("rr_idle", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd5);
      check_fx("fx_idle", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd0);

      // Single request from LOAD1; holding Req one extra edge must be masked.
      if_rr.Req_data[2] = 16'h0042;
      if_rr.Req = 4'b0100;
      tick();
      check_rr("single", 4'b0100, 1'b1, 3'd3, 16'h0042, 16'd6);
      tick();
      check_rr("masked", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd6);
      if_rr.Req = 4'b0000;
      tick();

      // Fixed priority: ADD1/LOAD2 alternate, ADD2 joins mid-stream.
      for (int i = 0; i < 7; i++) begin
         if_fx.Req = fx_req[i];
         tick();
         check_fx($sformatf("fx%0d", i), 4'b0001 << fx_win[i], 1'b1,
                  3'(fx_win[i] + 1), 16'hB000 + 16'(fx_win[i]), 16'(i + 1));
      end
      if_fx.Req = 4'b0000;

      // Pointer sits at 3: LOAD2 wins first, then ADD2.
      if_rr.Req = 4'b1110;
      tick();
      check_rr("pre_rst0", 4'b1000, 1'b1, 3'd4, 16'hA003, 16'd7);
      tick();
      check_rr("pre_rst1", 4'b0010, 1'b1, 3'd2, 16'hA001, 16'd8);

      // Reset mid-stream while ADD2 holds the grant.
      rst = 1'b0;
      tick();
      check_rr("mid_rst", 4'b0000, 1'b0, 3'd0, 16'hFFF0, 16'd0);
      rst = 1'b1;
      tick();
      check_rr("post_rst", 4'b0010, 1'b1, 3'd2, 16'hA001, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
